ysyx_25020037_gpr_csr_commit: RTL and testbench
===============================================

// Module: ysyx_25020037_gpr_csr_commit
// PURPOSE
//   Consumer end of the WBU->GU write-back bus. Takes the one-cycle wbu_valid pulse and
//   wu_to_gu_bus, and commits results into the 32x32 GPR file and the machine CSR bank.
//   Sequences the ecall/mret trap updates and issues a PC redirect plus a commit pulse to
//   the IFU. Provides the architectural GPR and CSR read ports used by the IDU.
// PARAMETERS
//   BUS_WD    117          width of wu_to_gu_bus (must equal `WU_TO_GU_BUS_WD)
//   RST_MSTAT 32'h00001800 mstatus reset value (MPP=M)
// PORTS
//   clk            in   1    single clock, rising edge
//   rst            in   1    synchronous, active-low reset (0 = reset)
//   wbu_valid      in   1    one-cycle pulse: wu_to_gu_bus valid
//   wu_to_gu_bus   in   117  {pc[31:0],rd[4:0],csr_we,csr_waddr[11:0],is_ecall,is_mret,
//                            csr_wdata[31:0],gpr_we,result[31:0]} (MSB->LSB)
//   gu_ready       out  1    1 = can take wbu_valid with no buffering
//   gu_valid       out  1    one-cycle pulse: instruction fully committed
//   commit_pc      out  32   pc of the committed instruction (valid with gu_valid)
//   redirect_valid out  1    one-cycle pulse with gu_valid: fetch from dnpc
//   dnpc           out  32   redirect target (mtvec on ecall, mepc on mret)
//   raddr1/raddr2  in   5    GPR read addresses
//   rdata1/rdata2  out  32   combinational GPR read data (x0 reads 0)
//   csr_raddr      in   12   CSR read address
//   csr_rdata      out  32   combinational CSR read data (unimplemented CSR reads 0)
// BEHAVIOUR
//   Reset (rst=0 at posedge): GPRs=0; mtvec/mepc/mcause=0; mstatus=RST_MSTAT; gu_valid=0;
//     redirect_valid=0; dnpc=0; commit_pc=0; gu_ready=1; pending=0; FSM->IDLE.
//     Reset mid-trap abandons the trap: no mepc/mcause update after the reset edge.
//   CSRs implemented: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
//   Reads: no write->read bypass; a write is visible on read ports from the cycle after
//     its commit edge.
//   FSM IDLE (gu_ready=1): on a pending entry (else wbu_valid), at the same edge:
//     - normal: if gpr_we && rd!=0 then GPR[rd]<=result; if csr_we, CSR[csr_waddr]<=csr_wdata;
//       gu_valid=1 and commit_pc=pc next cycle; stay IDLE.
//     - is_mret: mstatus.MIE<=MPIE, MPIE<=1; redirect_valid=1, dnpc=mepc (pre-edge value),
//       gu_valid=1; stay IDLE.
//     - is_ecall: mepc<=pc; mcause<=32'd11; -> TRAP. GPR and CSR writes of this entry are
//       dropped (ecall wins over csr_we/gpr_we).
//   FSM TRAP (gu_ready=0, one cycle): mstatus.MPIE<=MIE, MIE<=0; gu_valid=1,
//     redirect_valid=1, dnpc=mtvec; -> IDLE.
//   Latency: 1 cycle wbu_valid->gu_valid for normal/mret; 2 cycles for ecall.
//   Buffer: wbu_valid while gu_ready=0 is latched into a 1-entry pending register and
//     processed in the next IDLE cycle, before any new wbu_valid. wbu_valid arriving while
//     pending is full is a protocol error: sim assertion; that entry is dropped.
//   Simultaneous pending + new wbu_valid in IDLE: process pending; latch new into pending.
//   gu_valid and redirect_valid are single-cycle pulses, 0 otherwise.
//   csr_we to an unimplemented address: ignored, commit still reported.
// TESTING
//   1 Reset: hold rst=0 for 2 clk -> all rdata=0, csr_rdata(0x300)=0x1800, gu_ready=1,
//     no gu_valid pulse.
//   2 wbu_valid, gpr_we=1, rd=5, result=0xDEADBEEF, pc=0x80000000 -> next cycle
//     gu_valid=1, commit_pc=0x80000000, rdata1(raddr1=5)=0xDEADBEEF; rd=0 -> x0 stays 0.
//   3 csr_we=1, csr_waddr=0x305, csr_wdata=0x80001000 -> csr_rdata(0x305)=0x80001000.
//   4 mtvec=0x80001000, mstatus.MIE=1; ecall pc=0x80000010 -> cycle+1 gu_ready=0;
//     cycle+2 gu_valid=redirect_valid=1, dnpc=0x80001000, mepc=0x80000010,
//     mcause=11, MIE=0, MPIE=1.
//   5 wbu_valid during TRAP (gpr_we, rd=3, result=7) -> buffered, committed in the
//     following IDLE cycle; GPR[3]=7; commit order preserved.
//   6 mret with mepc=0x80000014 -> next cycle redirect_valid=1, dnpc=0x80000014,
//     MIE restored from MPIE; assert rst=0 during TRAP -> mepc/mcause not updated.

Source files
------------

// File: rtl/ysyx_25020037_gpr_csr_commit_if.sv
// Write-back bus between the WBU and the commit unit (GU), plus the
// architectural GPR/CSR read ports used by the IDU.
//   master : producer side (WBU/IDU): drives wbu_valid, wu_to_gu_bus and read addresses
//   slave  : commit unit: drives gu_ready, gu_valid, commit_pc, redirect_valid, dnpc
//            and the read data ports
interface ysyx_25020037_gpr_csr_commit_if #(
  parameter int BUS_WD = 117
);
  logic              wbu_valid;
  logic [BUS_WD-1:0] wu_to_gu_bus;
  logic              gu_ready;
  logic              gu_valid;
  logic [31:0]       commit_pc;
  logic              redirect_valid;
  logic [31:0]       dnpc;
  logic [4:0]        raddr1;
  logic [4:0]        raddr2;
  logic [31:0]       rdata1;
  logic [31:0]       rdata2;
  logic [11:0]       csr_raddr;
  logic [31:0]       csr_rdata;

  modport master (
    output wbu_valid, wu_to_gu_bus, raddr1, raddr2, csr_raddr,
    input  gu_ready, gu_valid, commit_pc, redirect_valid, dnpc,
           rdata1, rdata2, csr_rdata
  );

  modport slave (
    input  wbu_valid, wu_to_gu_bus, raddr1, raddr2, csr_raddr,
    output gu_ready, gu_valid, commit_pc, redirect_valid, dnpc,
           rdata1, rdata2, csr_rdata
  );
endinterface

// File: rtl/ysyx_25020037_gpr_csr_commit.sv
// Commit unit at the consumer end of the WBU->GU write-back bus.
// Commits results into the 32x32 GPR file and the machine CSR bank
// (mstatus/mtvec/mepc/mcause), sequences ecall/mret trap updates, and
// reports each committed instruction to the IFU with an optional redirect.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset (0 = reset)
//   wb   : slave modport of the write-back interface
//          in : wbu_valid, wu_to_gu_bus, raddr1, raddr2, csr_raddr
//          out: gu_ready, gu_valid, commit_pc, redirect_valid, dnpc,
//               rdata1, rdata2, csr_rdata (read data is combinational)
module ysyx_25020037_gpr_csr_commit #(
  parameter int          BUS_WD    = 117,
  parameter logic [31:0] RST_MSTAT = 32'h00001800
) (
  input logic clk,
  input logic rst,
  ysyx_25020037_gpr_csr_commit_if.slave wb
);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic        is_ecall;
    logic        is_mret;
    logic [31:0] csr_wdata;
    logic        gpr_we;
    logic [31:0] result;
  } wb_ent_t;

  typedef enum logic {S_IDLE, S_TRAP} state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam int          MIE         = 3;
  localparam int          MPIE        = 7;

  state_t      state_q, state_d;
  logic        pend_vld_p0, pend_vld_d;
  wb_ent_t     pend_ent_p0, pend_ent_d;
  wb_ent_t     in_ent, take_ent;
  logic        take_vld;
  logic        do_commit, do_mret, do_ecall, do_trap;

  logic [31:0] gpr [32];
  logic [31:0] mstatus, mtvec, mepc, mcause;

  logic        gu_valid_p1, redir_p1;
  logic [31:0] commit_pc_p1, dnpc_p1;

  assign in_ent = wb_ent_t'(wb.wu_to_gu_bus[BUS_WD-1:0]);

  // Selection: a buffered entry always goes before a fresh one so commit
  // order follows arrival order. Priority within an entry is ecall > mret >
  // normal; ecall and mret carry no GPR/CSR write of their own.
  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_p0;
    pend_ent_d = pend_ent_p0;
    take_vld   = 1'b0;
    take_ent   = in_ent;
    do_commit  = 1'b0;
    do_mret    = 1'b0;
    do_ecall   = 1'b0;
    do_trap    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_vld_p0) begin
          take_vld   = 1'b1;
          take_ent   = pend_ent_p0;
          pend_vld_d = wb.wbu_valid;
          pend_ent_d = in_ent;
        end else if (wb.wbu_valid) begin
          take_vld = 1'b1;
        end
        if (take_vld) begin
          if (take_ent.is_ecall) begin
            do_ecall = 1'b1;
            state_d  = S_TRAP;
          end else if (take_ent.is_mret) begin
            do_mret = 1'b1;
          end else begin
            do_commit = 1'b1;
          end
        end
      end
      S_TRAP: begin
        do_trap = 1'b1;
        state_d = S_IDLE;
        // A second arrival while the buffer is full is dropped (protocol error).
        if (wb.wbu_valid && !pend_vld_p0) begin
          pend_vld_d = 1'b1;
          pend_ent_d = in_ent;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // p0 -> p1: architectural state update and registered commit report
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_vld_p0  <= 1'b0;
      pend_ent_p0  <= '0;
      gu_valid_p1  <= 1'b0;
      redir_p1     <= 1'b0;
      commit_pc_p1 <= '0;
      dnpc_p1      <= '0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
      mstatus      <= RST_MSTAT;
      mtvec        <= '0;
      mepc         <= '0;
      mcause       <= '0;
    end else begin
      pend_vld_p0 <= pend_vld_d;
      pend_ent_p0 <= pend_ent_d;
      gu_valid_p1 <= do_commit | do_mret | do_trap;
      redir_p1    <= do_mret | do_trap;
      if (do_commit || do_mret) commit_pc_p1 <= take_ent.pc;
      // mepc already holds the ecall pc by the time the trap cycle reports it.
      if (do_trap) commit_pc_p1 <= mepc;
      if (do_mret) dnpc_p1 <= mepc;
      if (do_trap) dnpc_p1 <= mtvec;

      if (do_commit) begin
        if (take_ent.gpr_we && take_ent.rd != 5'd0) gpr[take_ent.rd] <= take_ent.result;
        if (take_ent.csr_we) begin
          case (take_ent.csr_waddr)
            CSR_MSTATUS: mstatus <= take_ent.csr_wdata;
            CSR_MTVEC:   mtvec   <= take_ent.csr_wdata;
            CSR_MEPC:    mepc    <= take_ent.csr_wdata;
            CSR_MCAUSE:  mcause  <= take_ent.csr_wdata;
            default: ;
          endcase
        end
      end
      if (do_mret) begin
        mstatus[MIE]  <= mstatus[MPIE];
        mstatus[MPIE] <= 1'b1;
      end
      if (do_ecall) begin
        mepc   <= take_ent.pc;
        mcause <= 32'd11;
      end
      if (do_trap) begin
        mstatus[MPIE] <= mstatus[MIE];
        mstatus[MIE]  <= 1'b0;
      end
    end
  end

  assign wb.gu_ready       = (state_q == S_IDLE);
  assign wb.gu_valid       = gu_valid_p1;
  assign wb.redirect_valid = redir_p1;
  assign wb.commit_pc      = commit_pc_p1;
  assign wb.dnpc           = dnpc_p1;

  assign wb.rdata1 = (wb.raddr1 == 5'd0) ? 32'd0 : gpr[wb.raddr1];
  assign wb.rdata2 = (wb.raddr2 == 5'd0) ? 32'd0 : gpr[wb.raddr2];

  always_comb begin
    case (wb.csr_raddr)
      CSR_MSTATUS: wb.csr_rdata = mstatus;
      CSR_MTVEC:   wb.csr_rdata = mtvec;
      CSR_MEPC:    wb.csr_rdata = mepc;
      CSR_MCAUSE:  wb.csr_rdata = mcause;
      default:     wb.csr_rdata = 32'd0;
    endcase
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(state_q == S_TRAP && pend_vld_p0 && wb.wbu_valid));

endmodule

// File: tb/tb_ysyx_25020037_gpr_csr_commit.sv
module tb_ysyx_25020037_gpr_csr_commit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  typedef struct {
    logic [31:0] pc;
    logic        redir;
    logic [31:0] dnpc;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  ysyx_25020037_gpr_csr_commit_if #(.BUS_WD(117)) bus_if ();

  ysyx_25020037_gpr_csr_commit #(.BUS_WD(117), .RST_MSTAT(32'h00001800)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [116:0] mk(input logic [31:0] pc, input logic [4:0] rd,
      input logic csr_we, input logic [11:0] waddr, input logic ecall, input logic mret,
      input logic [31:0] cdata, input logic gpr_we, input logic [31:0] res);
    return {pc, rd, csr_we, waddr, ecall, mret, cdata, gpr_we, res};
  endfunction

  // Drive one entry for the next edge and record the report it should produce.
  task automatic send(input logic [116:0] b, input logic expect_it, input logic redir,
                      input logic [31:0] dn, input int lat);
    exp_t e;
    @(negedge clk);
    bus_if.wbu_valid    = 1'b1;
    bus_if.wu_to_gu_bus = b;
    if (expect_it) begin
      e.pc = b[116:85]; e.redir = redir; e.dnpc = dn; e.cyc = cyc + lat;
      exp_q.push_back(e);
    end
  endtask

  task automatic quiet();
    @(negedge clk);
    bus_if.wbu_valid = 1'b0;
  endtask

  task automatic chk_gpr(input string name, input logic [4:0] a, input logic [31:0] exp);
    bus_if.raddr1 = a; bus_if.raddr2 = a;
    #1;
    check({name, "_r1"}, bus_if.rdata1, exp);
    check({name, "_r2"}, bus_if.rdata2, exp);
  endtask

  task automatic chk_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
    bus_if.csr_raddr = a;
    #1;
    check(name, bus_if.csr_rdata, exp);
  endtask

  // Monitor: every gu_valid pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_if.gu_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_gu_valid", bus_if.commit_pc, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("commit_pc", bus_if.commit_pc, e.pc);
          check("redirect_valid", {31'd0, bus_if.redirect_valid}, {31'd0, e.redir});
          if (e.redir) check("dnpc", bus_if.dnpc, e.dnpc);
          check("commit_cycle", cyc, e.cyc);
        end
      end else if (bus_if.redirect_valid === 1'b1) begin
        check("redirect_without_commit", {31'd0, bus_if.gu_valid}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.wbu_valid    = 1'b0;
    bus_if.wu_to_gu_bus = '0;
    bus_if.raddr1       = 5'd0;
    bus_if.raddr2       = 5'd0;
    bus_if.csr_raddr    = 12'h000;

    // Reset held for two edges
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_gpr("rst_x5", 5'd5, 32'd0);
    chk_gpr("rst_x31", 5'd31, 32'd0);
    chk_csr("rst_mstatus", 12'h300, 32'h00001800);
    chk_csr("rst_mtvec", 12'h305, 32'd0);
    chk_csr("rst_mepc", 12'h341, 32'd0);
    chk_csr("rst_mcause", 12'h342, 32'd0);
    check("rst_gu_ready", {31'd0, bus_if.gu_ready}, 32'd1);
    rst = 1'b1;

    // Normal GPR writes, x0 stays zero
    send(mk(32'h80000000, 5'd5, 1'b0, 12'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF), 1, 0, 0, 1);
    send(mk(32'h80000004, 5'd0, 1'b0, 12'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h12345678), 1, 0, 0, 1);
    quiet();
    chk_gpr("x5", 5'd5, 32'hDEADBEEF);
    chk_gpr("x0", 5'd0, 32'd0);

    // CSR writes: mtvec, mstatus (MIE=1, MPIE=0), unimplemented address
    send(mk(32'h80000008, 5'd0, 1'b1, 12'h305, 1'b0, 1'b0, 32'h80001000, 1'b0, 32'h0), 1, 0, 0, 1);
    send(mk(32'h8000000C, 5'd0, 1'b1, 12'h300, 1'b0, 1'b0, 32'h00001808, 1'b0, 32'h0), 1, 0, 0, 1);
    send(mk(32'h80000040, 5'd0, 1'b1, 12'h7C0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0), 1, 0, 0, 1);
    quiet();
    chk_csr("mtvec", 12'h305, 32'h80001000);
    chk_csr("mstatus_w", 12'h300, 32'h00001808);
    chk_csr("unimpl_csr", 12'h7C0, 32'd0);

    // ecall (its gpr write dropped), F arrives in TRAP, G arrives with F pending
    send(mk(32'h80000010, 5'd9, 1'b0, 12'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h55), 1, 1, 32'h80001000, 2);
    send(mk(32'h80000014, 5'd3, 1'b0, 12'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'd7), 1, 0, 0, 2);
    check("trap_gu_ready", {31'd0, bus_if.gu_ready}, 32'd0);
    send(mk(32'h80000018, 5'd4, 1'b0, 12'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h44), 1, 0, 0, 2);
    chk_csr("ecall_mepc", 12'h341, 32'h80000010);
    chk_csr("ecall_mcause", 12'h342, 32'd11);
    chk_csr("ecall_mstatus", 12'h300, 32'h00001880);
    check("post_trap_gu_ready", {31'd0, bus_if.gu_ready}, 32'd1);
    chk_gpr("x3_not_yet", 5'd3, 32'd0);
    quiet();
    chk_gpr("x3", 5'd3, 32'd7);
    chk_gpr("x4_not_yet", 5'd4, 32'd0);
    @(negedge clk);
    chk_gpr("x4", 5'd4, 32'h44);
    chk_gpr("x9_dropped", 5'd9, 32'd0);

    // mepc write then back-to-back mret
    send(mk(32'h8000001C, 5'd0, 1'b1, 12'h341, 1'b0, 1'b0, 32'h80000014, 1'b0, 32'h0), 1, 0, 0, 1);
    send(mk(32'h80000020, 5'd0, 1'b0, 12'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0), 1, 1, 32'h80000014, 1);
    quiet();
    chk_csr("mret_mstatus", 12'h300, 32'h00001888);
    chk_csr("mret_mepc", 12'h341, 32'h80000014);

    // Reset during TRAP abandons the trap
    send(mk(32'h80000024, 5'd0, 1'b0, 12'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0), 0, 0, 0, 0);
    @(negedge clk);
    bus_if.wbu_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_csr("rst_trap_mepc", 12'h341, 32'd0);
    chk_csr("rst_trap_mcause", 12'h342, 32'd0);
    chk_csr("rst_trap_mstatus", 12'h300, 32'h00001800);
    chk_gpr("rst_trap_x5", 5'd5, 32'd0);
    check("rst_trap_gu_ready", {31'd0, bus_if.gu_ready}, 32'd1);

    // Operation resumes after reset
    send(mk(32'h80000028, 5'd5, 1'b0, 12'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'd1), 1, 0, 0, 1);
    quiet();
    chk_gpr("x5_after_rst", 5'd5, 32'd1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
